// File: rtl/synthesijer_div64_arbiter.sv
// Round-robin arbiter sharing one pipelined signed 64-bit divider
// among NREQ requesters, with an in-order tag FIFO steering results back.
//
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   req_valid/req_ready   : per-requester strobe / one-hot grant
//   req_a/req_b           : packed 64-bit operands, slice i = [64i+63:64i]
//   resp_valid            : one-hot 1-cycle result pulse
//   resp_quantient/_remainder/_dbz : shared result bus
//   div_reset/div_a/div_b/div_nd   : to the divider
//   div_quantient/_remainder/_valid: from the divider
//   err_orphan            : sticky, result seen with no tag outstanding
module synthesijer_div64_arbiter #(
  parameter int NREQ            = 4,
  parameter int TAGW            = 2,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [64*NREQ-1:0] req_a,
  input  logic [64*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   resp_valid,
  output logic [63:0]       resp_quantient,
  output logic [63:0]       resp_remainder,
  output logic              resp_dbz,
  output logic              div_reset,
  output logic [63:0]       div_a,
  output logic [63:0]       div_b,
  output logic              div_nd,
  input  logic [63:0]       div_quantient,
  input  logic [63:0]       div_remainder,
  input  logic              div_valid,
  output logic              err_orphan
);

  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int EW = TAGW + 1;

  logic [CW-1:0]   inflight_q, inflight_d;
  logic [TAGW-1:0] rr_q, rr_d;
  logic [63:0]     div_a_q, div_a_d;
  logic [63:0]     div_b_q, div_b_d;
  logic            div_nd_q, div_nd_d;
  logic [TAGW-1:0] tag_q, tag_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rv_q, rv_d;
  logic [63:0]     rq_q, rq_d;
  logic [63:0]     rr_rem_q, rr_rem_d;
  logic            rdbz_q, rdbz_d;
  logic            err_q, err_d;

  logic [EW-1:0]   fifo_mem [MAX_OUTSTANDING];
  logic [EW-1:0]   head;
  logic [NREQ-1:0] grant;
  logic [TAGW-1:0] gidx;
  logic            accept;
  logic            has_credit;
  logic            push;
  logic            pop;
  logic            orphan;
  int              j;

  assign has_credit = inflight_q < CW'(MAX_OUTSTANDING);

  // Scan downward so the lowest offset from rr_q wins last.
  always_comb begin
    grant = '0;
    gidx  = '0;
    j     = 0;
    if (reset_n && has_credit) begin
      for (int i = NREQ - 1; i >= 0; i--) begin
        j = int'(rr_q) + i;
        if (j >= NREQ) j = j - NREQ;
        if (req_valid[j]) begin
          grant = NREQ'(1) << j;
          gidx  = TAGW'(j);
        end
      end
    end
  end

  assign accept = |grant;

  // Tag is pushed the cycle the operands reach the divider.
  assign push   = div_nd_q;
  assign pop    = div_valid && (cnt_q != '0);
  assign orphan = div_valid && (cnt_q == '0);
  assign head   = fifo_mem[rd_q];

  always_comb begin
    rr_d     = rr_q;
    div_a_d  = div_a_q;
    div_b_d  = div_b_q;
    tag_d    = tag_q;
    div_nd_d = accept;
    if (accept) begin
      rr_d    = (gidx == TAGW'(NREQ - 1)) ? '0 : gidx + TAGW'(1);
      div_a_d = req_a[int'(gidx)*64 +: 64];
      div_b_d = req_b[int'(gidx)*64 +: 64];
      tag_d   = gidx;
    end
    wr_d       = wr_q + PW'(push);
    rd_d       = rd_q + PW'(pop);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    inflight_d = inflight_q + CW'(accept) - CW'(pop);
    rv_d       = '0;
    rq_d       = rq_q;
    rr_rem_d   = rr_rem_q;
    rdbz_d     = rdbz_q;
    if (pop) begin
      rv_d     = NREQ'(1) << head[TAGW-1:0];
      rq_d     = div_quantient;
      rr_rem_d = div_remainder;
      rdbz_d   = head[TAGW];
    end
    err_d = err_q | orphan;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      inflight_q <= '0;
      rr_q       <= '0;
      div_a_q    <= '0;
      div_b_q    <= '0;
      div_nd_q   <= 1'b0;
      tag_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rv_q       <= '0;
      rq_q       <= '0;
      rr_rem_q   <= '0;
      rdbz_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      div_nd_q   <= div_nd_d;
      tag_q      <= tag_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rv_q       <= rv_d;
      rq_q       <= rq_d;
      rr_rem_q   <= rr_rem_d;
      rdbz_q     <= rdbz_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_q] <= {div_b_q == '0, tag_q};
  end

  assign req_ready      = grant;
  assign div_reset      = ~reset_n;
  assign div_a          = div_a_q;
  assign div_b          = div_b_q;
  assign div_nd         = div_nd_q;
  assign resp_valid     = rv_q;
  assign resp_quantient = rq_q;
  assign resp_remainder = rr_rem_q;
  assign resp_dbz       = rdbz_q;
  assign err_orphan     = err_q;

endmodule

// File: tb/tb_synthesijer_div64_arbiter.sv
// Bench for synthesijer_div64_arbiter: two instances (L=4/MAX=32 and
// L=8/MAX=4) each driving a behavioural pipelined divider.
module tb_synthesijer_div64_arbiter;
  localparam int NREQ = 4;
  localparam int LA   = 4;
  localparam int LB   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance A
  logic [3:0]   va, ra, rva;
  logic [255:0] aa, ba;
  logic [63:0]  rqa, rra, daa, dba, dqa, dra_r;
  logic         rdbza, dra, nda, dva, erra, inj_a;

  // instance B
  logic [3:0]   vb, rb, rvb;
  logic [255:0] ab, bb;
  logic [63:0]  rqb, rrb, dab, dbb, dqb, drb_r;
  logic         rdbzb, drb, ndb, dvb, errb;

  synthesijer_div64_arbiter #(
    .NREQ(4), .TAGW(2), .MAX_OUTSTANDING(32)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(va), .req_ready(ra),
    .req_a(aa), .req_b(ba),
    .resp_valid(rva), .resp_quantient(rqa),
    .resp_remainder(rra), .resp_dbz(rdbza),
    .div_reset(dra), .div_a(daa), .div_b(dba),
    .div_nd(nda), .div_quantient(dqa),
    .div_remainder(dra_r), .div_valid(dva),
    .err_orphan(erra)
  );

  synthesijer_div64_arbiter #(
    .NREQ(4), .TAGW(2), .MAX_OUTSTANDING(4)
  ) dutb (
    .clk(clk), .reset_n(reset_n),
    .req_valid(vb), .req_ready(rb),
    .req_a(ab), .req_b(bb),
    .resp_valid(rvb), .resp_quantient(rqb),
    .resp_remainder(rrb), .resp_dbz(rdbzb),
    .div_reset(drb), .div_a(dab), .div_b(dbb),
    .div_nd(ndb), .div_quantient(dqb),
    .div_remainder(drb_r), .div_valid(dvb),
    .err_orphan(errb)
  );

  function automatic logic [63:0] mq(logic signed [63:0] a,
                                     logic signed [63:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [63:0] mr(logic signed [63:0] a,
                                     logic signed [63:0] b);
    if (b == '0) return a;
    return a % b;
  endfunction

  // divider models: result valid L cycles after div_nd
  logic [LA-1:0]      pva;
  logic signed [63:0] paa [LA];
  logic signed [63:0] pba [LA];
  always @(posedge clk) begin
    if (dra) pva <= '0;
    else     pva <= {pva[LA-2:0], nda};
    paa[0] <= daa;
    pba[0] <= dba;
    for (int i = 1; i < LA; i++) begin
      paa[i] <= paa[i-1];
      pba[i] <= pba[i-1];
    end
  end
  assign dva   = pva[LA-1] | inj_a;
  assign dqa   = mq(paa[LA-1], pba[LA-1]);
  assign dra_r = mr(paa[LA-1], pba[LA-1]);

  logic [LB-1:0]      pvb;
  logic signed [63:0] pab [LB];
  logic signed [63:0] pbb [LB];
  always @(posedge clk) begin
    if (drb) pvb <= '0;
    else     pvb <= {pvb[LB-2:0], ndb};
    pab[0] <= dab;
    pbb[0] <= dbb;
    for (int i = 1; i < LB; i++) begin
      pab[i] <= pab[i-1];
      pbb[i] <= pbb[i-1];
    end
  end
  assign dvb   = pvb[LB-1];
  assign dqb   = mq(pab[LB-1], pbb[LB-1]);
  assign drb_r = mr(pab[LB-1], pbb[LB-1]);

  typedef struct {
    logic [3:0]  v;
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          c;
  } resp_t;
  resp_t rq_a[$];
  always @(negedge clk)
    if (|rva) rq_a.push_back('{rva, rqa, rra, rdbza, cyc});

  typedef struct {
    int                 k;
    logic signed [63:0] a;
    logic signed [63:0] b;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic               dbz;
  } vec_t;
  vec_t vt [7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply_vec(input int id, input vec_t v);
    int n;
    int acc;
    resp_t r;
    logic [3:0] oh;
    oh = 4'b0001 << v.k;
    @(negedge clk);
    aa[v.k*64 +: 64] = v.a;
    ba[v.k*64 +: 64] = v.b;
    va = oh;
    #1;
    n = 0;
    while (ra !== oh && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d ready", id), 64'(ra), 64'(oh));
    acc = cyc;
    @(negedge clk);
    va = '0;
    chk($sformatf("v%0d div_nd", id), 64'(nda), 64'(1'b1));
    chk($sformatf("v%0d div_a", id), daa, v.a);
    chk($sformatf("v%0d div_b", id), dba, v.b);
    n = 0;
    while (rq_a.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rq_a.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL v%0d resp timeout: got none expected 1", id);
    end else begin
      r = rq_a.pop_front();
      chk($sformatf("v%0d resp_valid", id), 64'(r.v), 64'(oh));
      chk($sformatf("v%0d latency", id), 64'(r.c - acc), 64'(LA + 2));
      chk($sformatf("v%0d quot", id), r.q, v.q);
      chk($sformatf("v%0d rem", id), r.r, v.r);
      chk($sformatf("v%0d dbz", id), 64'(r.dbz), 64'(v.dbz));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  logic signed [63:0] ea [4];
  logic signed [63:0] eb [4];
  logic signed [63:0] eq [4];
  logic signed [63:0] er [4];

  initial begin
    int c0;
    int n;
    int mcnt;
    int nacc;
    int first_resp;
    int acc5;
    int maxc;
    resp_t r;

    vt[0] = '{2, 64'sd100, 64'sd7, 64'sd14, 64'sd2, 1'b0};
    vt[1] = '{0, -64'sd9, 64'sd2, -64'sd4, -64'sd1, 1'b0};
    vt[2] = '{1, 64'sd5, 64'sd0, -64'sd1, 64'sd5, 1'b1};
    vt[3] = '{3, 64'sd6, 64'sd3, 64'sd2, 64'sd0, 1'b0};
    vt[4] = '{1, -64'sd100, 64'sd7, -64'sd14, -64'sd2, 1'b0};
    vt[5] = '{3, 64'sd7, -64'sd3, -64'sd2, 64'sd1, 1'b0};
    vt[6] = '{0, 64'sd1000000000000, 64'sd3,
              64'sd333333333333, 64'sd1, 1'b0};

    ea = '{-64'sd9, 64'sd100, -64'sd100, 64'sd7};
    eb = '{64'sd2, 64'sd7, 64'sd7, -64'sd3};
    eq = '{-64'sd4, 64'sd14, -64'sd14, -64'sd2};
    er = '{-64'sd1, 64'sd2, -64'sd2, 64'sd1};

    inj_a   = 1'b0;
    vb      = '0;
    ab      = '0;
    bb      = '0;
    reset_n = 1'b0;
    va      = 4'hF;
    for (int i = 0; i < 4; i++) begin
      aa[i*64 +: 64] = ea[i];
      ba[i*64 +: 64] = eb[i];
    end
    repeat (2) @(negedge clk);
    #1;
    chk("rst ready", 64'(ra), 64'(0));
    chk("rst div_reset", 64'(dra), 64'(1));
    chk("rst resp_valid", 64'(rva), 64'(0));
    chk("rst quot", rqa, 64'(0));
    chk("rst rem", rra, 64'(0));
    chk("rst dbz", 64'(rdbza), 64'(0));
    chk("rst div_nd", 64'(nda), 64'(0));
    chk("rst div_a", daa, 64'(0));
    chk("rst div_b", dba, 64'(0));
    chk("rst err", 64'(erra), 64'(0));

    // all requesters valid from reset: grants rotate one per cycle
    @(negedge clk);
    reset_n = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("rr grant %0d", i), 64'(ra),
          64'(4'b0001 << (i % 4)));
      @(negedge clk);
    end
    va = '0;
    n = 0;
    while (rq_a.size() < 8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rr resp count", 64'(rq_a.size()), 64'(8));
    for (int i = 0; i < 8; i++) begin
      if (rq_a.size() != 0) begin
        r = rq_a.pop_front();
        chk($sformatf("rr resp %0d who", i), 64'(r.v),
            64'(4'b0001 << (i % 4)));
        chk($sformatf("rr resp %0d cyc", i), 64'(r.c),
            64'(c0 + LA + 2 + i));
        chk($sformatf("rr resp %0d quot", i), r.q, eq[i % 4]);
        chk($sformatf("rr resp %0d rem", i), r.r, er[i % 4]);
      end
    end

    for (int i = 0; i < 7; i++) apply_vec(i, vt[i]);

    // orphan result
    repeat (3) @(negedge clk);
    chk("orphan pre", 64'(erra), 64'(0));
    inj_a = 1'b1;
    @(negedge clk);
    inj_a = 1'b0;
    chk("orphan set", 64'(erra), 64'(1));
    repeat (4) @(negedge clk);
    chk("orphan sticky", 64'(erra), 64'(1));
    chk("orphan no resp", 64'(rq_a.size()), 64'(0));
    apply_vec(10, vt[3]);

    // reset with three operations in flight
    @(negedge clk);
    aa[0 +: 64]   = 64'sd50;
    ba[0 +: 64]   = 64'sd5;
    aa[64 +: 64]  = 64'sd51;
    ba[64 +: 64]  = 64'sd5;
    aa[128 +: 64] = 64'sd52;
    ba[128 +: 64] = 64'sd5;
    va = 4'b0111;
    repeat (3) @(negedge clk);
    va = '0;
    chk("mid nd", 64'(nda), 64'(1));
    rq_a.delete();
    reset_n = 1'b0;
    #1;
    chk("mid ready", 64'(ra), 64'(0));
    chk("mid div_reset", 64'(dra), 64'(1));
    @(negedge clk);
    chk("mid resp_valid", 64'(rva), 64'(0));
    chk("mid quot", rqa, 64'(0));
    chk("mid rem", rra, 64'(0));
    chk("mid div_nd", 64'(nda), 64'(0));
    chk("mid div_a", daa, 64'(0));
    chk("mid div_b", dba, 64'(0));
    chk("mid err", 64'(erra), 64'(0));
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("mid stale", 64'(rq_a.size()), 64'(0));
    apply_vec(20, vt[0]);

    // credit limit on the MAX=4, L=8 instance
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ab[i*64 +: 64] = 64'sd20 + 64'(i);
      bb[i*64 +: 64] = 64'sd3;
    end
    vb = 4'hF;
    mcnt = 0;
    nacc = 0;
    first_resp = -1;
    acc5 = -2;
    maxc = 0;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (|rvb) begin
        mcnt--;
        if (first_resp < 0) first_resp = cyc;
      end
      if (mcnt == 4) chk($sformatf("credit hold t%0d", t),
                         64'(rb), 64'(0));
      if (|rb) begin
        nacc++;
        mcnt++;
        if (nacc == 5) begin
          acc5 = cyc;
          chk("credit 5th grant", 64'(rb), 64'(1));
        end
      end
      if (mcnt > maxc) maxc = mcnt;
      @(negedge clk);
    end
    vb = '0;
    chk("credit resume", 64'(acc5), 64'(first_resp));
    chk("credit max", 64'(maxc), 64'(4));
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
